// File: rtl/urs_1_pio_arb_pkg.sv
// Shared definitions for the two-requester PIO arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package urs_1_pio_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 2;

    // IDLE -> ACCESS -> RESP -> IDLE; the encoding is fixed so it reads
    // the same in waveforms and in any software-visible debug path.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/urs_1_rr_arb2.sv
// Two-way round-robin grant: one-hot grant among req, tie broken against last_grant.
// Latency: purely combinational, no state (last_grant lives in the parent).
// Backpressure: none; the parent gates grants with its own FSM state.
//   req[1:0]    in   request vector (bit K = requester K valid)
//   last_grant  in   index of the requester granted most recently
//   grant[1:0]  out  one-hot grant, all zero when nothing requests
module urs_1_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A requester wins if it is alone, or if it was not the last winner.
    assign grant[0] = req[0] && (!req[1] || (last_grant != 1'b0));
    assign grant[1] = req[1] && (!req[0] || (last_grant != 1'b1));

endmodule

// File: rtl/urs_1_pio_arbiter.sv
// Shares one Avalon-MM PIO slave between two requesters, round-robin, one access per transaction.
// Latency: handshake -> 1-cycle chipselect strobe -> response valid next cycle (>= 3 cycles/transaction).
// Backpressure: rK_ready only in IDLE; response held until rK_rready, no new grant in the release cycle.
//   clk, reset_n                       clock, async active-low reset
//   rK_valid/ready/write/addr/wdata    request channel of requester K (K = 0,1)
//   rK_rvalid/rready/rdata             response channel of requester K
//   address/chipselect/write_n/
//   writedata/readdata                 PIO s1 slave pins (outputs registered)
module urs_1_pio_arbiter
    import urs_1_pio_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rvalid,
    input  logic              r0_rready,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rvalid,
    input  logic              r1_rready,
    output logic [DATA_W-1:0] r1_rdata,

    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       win;          // requester owning the current transaction
    logic [1:0] grant;
    logic       in_idle;
    logic       hs;
    logic       win_rready;

    urs_1_rr_arb2 u_arb (
        .req        ({r1_valid, r0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Grants are only offered in IDLE; outside it the requests are ignored.
    assign in_idle    = (state == ST_IDLE);
    assign r0_ready   = in_idle && grant[0];
    assign r1_ready   = in_idle && grant[1];
    assign hs         = r0_ready || r1_ready;
    assign win_rready = win ? r1_rready : r0_rready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (hs) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   if (win_rready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;       // r0 wins the first tie
            win        <= 1'b0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= '0;
            writedata  <= '0;
            r0_rvalid  <= 1'b0;
            r1_rvalid  <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        // The slave output registers double as the payload latch.
                        win        <= r1_ready;
                        last_grant <= r1_ready;
                        chipselect <= 1'b1;
                        write_n    <= ~(r1_ready ? r1_write : r0_write);
                        address    <= r1_ready ? r1_addr  : r0_addr;
                        writedata  <= r1_ready ? r1_wdata : r0_wdata;
                    end
                end
                ST_ACCESS: begin
                    // write_n still reflects the strobe: high means this was a read.
                    chipselect <= 1'b0;
                    write_n    <= 1'b1;
                    if (win) begin
                        r1_rvalid <= 1'b1;
                        r1_rdata  <= write_n ? readdata : '0;
                    end else begin
                        r0_rvalid <= 1'b1;
                        r0_rdata  <= write_n ? readdata : '0;
                    end
                end
                ST_RESP: begin
                    if (win_rready) begin
                        if (win) r1_rvalid <= 1'b0;
                        else     r0_rvalid <= 1'b0;
                    end
                end
                default: begin
                    chipselect <= 1'b0;
                    write_n    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_urs_1_pio_arbiter.sv
// Directed bench for urs_1_pio_arbiter with a zero-wait PIO output slave model.
// Latency: n/a (testbench).
// Backpressure: requesters hold valid until ready and pulse rready once per response.
module tb_urs_1_pio_arbiter;

    localparam int LIMIT = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r0_valid, r0_ready, r0_write, r0_rvalid, r0_rready;
    logic [1:0]  r0_addr;
    logic [31:0] r0_wdata, r0_rdata;
    logic        r1_valid, r1_ready, r1_write, r1_rvalid, r1_rready;
    logic [1:0]  r1_addr;
    logic [31:0] r1_wdata, r1_rdata;
    logic [1:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata, readdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    urs_1_pio_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_write   (r0_write),
        .r0_addr    (r0_addr),
        .r0_wdata   (r0_wdata),
        .r0_rvalid  (r0_rvalid),
        .r0_rready  (r0_rready),
        .r0_rdata   (r0_rdata),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_write   (r1_write),
        .r1_addr    (r1_addr),
        .r1_wdata   (r1_wdata),
        .r1_rvalid  (r1_rvalid),
        .r1_rready  (r1_rready),
        .r1_rdata   (r1_rdata),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    // PIO output slave: data_out register at address 0, other addresses read 0.
    logic [31:0] out_port;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                     out_port <= 32'd0;
        else if (chipselect && !write_n && address == 2'd0) out_port <= writedata;
    end
    assign readdata = (address == 2'd0) ? out_port : 32'd0;

    // Monitors sampled on the falling edge: strobe payload log and response counts.
    logic [31:0] wlog[$];
    int          rsp_cnt0 = 0;
    int          rsp_cnt1 = 0;
    logic        prev_rv0 = 1'b0;
    logic        prev_rv1 = 1'b0;
    always @(negedge clk) begin
        if (chipselect && !write_n) wlog.push_back(writedata);
        if (r0_rvalid && !prev_rv0) rsp_cnt0++;
        if (r1_rvalid && !prev_rv1) rsp_cnt1++;
        prev_rv0 = r0_rvalid;
        prev_rv1 = r1_rvalid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int k, input logic v, input logic wr,
                             input logic [1:0] a, input logic [31:0] d);
        if (k == 0) begin
            r0_valid = v; r0_write = wr; r0_addr = a; r0_wdata = d;
        end else begin
            r1_valid = v; r1_write = wr; r1_addr = a; r1_wdata = d;
        end
    endtask

    task automatic set_rready(input int k, input logic v);
        if (k == 0) r0_rready = v;
        else        r1_rready = v;
    endtask

    function automatic logic get_ready(input int k);
        return (k == 0) ? r0_ready : r1_ready;
    endfunction

    function automatic logic get_rvalid(input int k);
        return (k == 0) ? r0_rvalid : r1_rvalid;
    endfunction

    function automatic logic [31:0] get_rdata(input int k);
        return (k == 0) ? r0_rdata : r1_rdata;
    endfunction

    // Full transaction for requester k, entered and left on a falling edge.
    task automatic xact(input int k, input logic wr, input logic [1:0] a,
                        input logic [31:0] d, output logic [31:0] rd);
        int n;
        drive_req(k, 1'b1, wr, a, d);
        #1;
        n = 0;
        while (!get_ready(k) && n < LIMIT) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("r%0d_handshake_wait", k), 32'(n < LIMIT), 32'd1);
        @(negedge clk);
        drive_req(k, 1'b0, 1'b0, 2'd0, 32'd0);
        n = 0;
        while (!get_rvalid(k) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("r%0d_response_wait", k), 32'(n < LIMIT), 32'd1);
        rd = get_rdata(k);
        set_rready(k, 1'b1);
        @(negedge clk);
        set_rready(k, 1'b0);
    endtask

    logic [31:0] rd;
    logic [31:0] exp_log [8] = '{32'h1, 32'h10, 32'h2, 32'h20, 32'h3, 32'h30, 32'h4, 32'h40};

    initial begin
        reset_n = 1'b0;
        drive_req(0, 1'b0, 1'b0, 2'd0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 2'd0, 32'd0);
        r0_rready = 1'b0;
        r1_rready = 1'b0;

        // 1. reset values
        #12;
        chk("rst_cs", 32'(chipselect), 32'd0);
        chk("rst_write_n", 32'(write_n), 32'd1);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
        chk("rst_rdata0", r0_rdata, 32'd0);
        chk("rst_rdata1", r1_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_cs", 32'(chipselect), 32'd0);
            chk("idle_write_n", 32'(write_n), 32'd1);
        end
        chk("idle_ready", {30'd0, r1_ready, r0_ready}, 32'd0);

        // 2. r0 write 0xDEADBEEF at address 0
        drive_req(0, 1'b1, 1'b1, 2'd0, 32'hDEADBEEF);
        #1;
        chk("t2_r0_ready", 32'(r0_ready), 32'd1);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("t2_cs_high", 32'(chipselect), 32'd1);
        chk("t2_write_n_low", 32'(write_n), 32'd0);
        chk("t2_writedata", writedata, 32'hDEADBEEF);
        chk("t2_rvalid_early", 32'(r0_rvalid), 32'd0);
        @(negedge clk);
        chk("t2_cs_low", 32'(chipselect), 32'd0);
        chk("t2_write_n_high", 32'(write_n), 32'd1);
        chk("t2_r0_rvalid", 32'(r0_rvalid), 32'd1);
        chk("t2_r0_rdata", r0_rdata, 32'd0);
        chk("t2_out_port", out_port, 32'hDEADBEEF);
        chk("t2_r1_rvalid", 32'(r1_rvalid), 32'd0);
        r0_rready = 1'b1;
        @(negedge clk);
        r0_rready = 1'b0;
        chk("t2_rvalid_clear", 32'(r0_rvalid), 32'd0);

        // 3. r1 reads
        xact(1, 1'b0, 2'd0, 32'd0, rd);
        chk("t3_read0", rd, 32'hDEADBEEF);
        xact(1, 1'b0, 2'd2, 32'd0, rd);
        chk("t3_read2", rd, 32'd0);
        chk("t3_out_port", out_port, 32'hDEADBEEF);

        // 4. contention, four writes each
        wlog.delete();
        rsp_cnt0 = 0;
        rsp_cnt1 = 0;
        fork
            begin
                logic [31:0] rd0;
                for (int i = 0; i < 4; i++) xact(0, 1'b1, 2'd0, 32'(i + 1), rd0);
            end
            begin
                logic [31:0] rd1;
                for (int j = 0; j < 4; j++) xact(1, 1'b1, 2'd0, 32'((j + 1) * 16), rd1);
            end
        join
        chk("t4_strobe_count", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t4_order%0d", i), (i < wlog.size()) ? wlog[i] : 32'hFFFF_FFFF, exp_log[i]);
        chk("t4_out_port", out_port, 32'h40);
        chk("t4_rsp_r0", 32'(rsp_cnt0), 32'd4);
        chk("t4_rsp_r1", 32'(rsp_cnt1), 32'd4);

        // 5. r0 stalls its response while r1 waits
        drive_req(0, 1'b1, 1'b1, 2'd0, 32'h77);
        drive_req(1, 1'b1, 1'b0, 2'd0, 32'd0);
        #1;
        chk("t5_r0_ready", 32'(r0_ready), 32'd1);
        chk("t5_r1_ready_tie", 32'(r1_ready), 32'd0);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("t5_cs_access", 32'(chipselect), 32'd1);
        chk("t5_r1_ready_access", 32'(r1_ready), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_r0_rvalid", 32'(r0_rvalid), 32'd1);
            chk("t5_hold_r1_ready", 32'(r1_ready), 32'd0);
            chk("t5_hold_cs", 32'(chipselect), 32'd0);
            @(negedge clk);
        end
        r0_rready = 1'b1;
        #1;
        chk("t5_release_r1_ready", 32'(r1_ready), 32'd0);
        @(negedge clk);
        r0_rready = 1'b0;
        #1;
        chk("t5_r0_rvalid_clear", 32'(r0_rvalid), 32'd0);
        chk("t5_r1_granted", 32'(r1_ready), 32'd1);
        @(negedge clk);
        drive_req(1, 1'b0, 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        chk("t5_r1_rvalid", 32'(r1_rvalid), 32'd1);
        chk("t5_r1_rdata", r1_rdata, 32'h77);
        r1_rready = 1'b1;
        @(negedge clk);
        r1_rready = 1'b0;

        // 6. reset during the strobe of an r0 write
        rsp_cnt0 = 0;
        drive_req(0, 1'b1, 1'b1, 2'd0, 32'h55);
        #1;
        chk("t6_r0_ready", 32'(r0_ready), 32'd1);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("t6_cs_access", 32'(chipselect), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_cs_abort", 32'(chipselect), 32'd0);
        chk("t6_write_n_abort", 32'(write_n), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("t6_no_rvalid", 32'(rsp_cnt0), 32'd0);
        drive_req(0, 1'b1, 1'b1, 2'd0, 32'h99);
        drive_req(1, 1'b1, 1'b1, 2'd0, 32'hAA);
        #1;
        chk("t6_tie_r0_ready", 32'(r0_ready), 32'd1);
        chk("t6_tie_r1_ready", 32'(r1_ready), 32'd0);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 2'd0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("t6_writedata", writedata, 32'h99);
        @(negedge clk);
        chk("t6_r0_rvalid", 32'(r0_rvalid), 32'd1);
        chk("t6_out_port", out_port, 32'h99);
        r0_rready = 1'b1;
        @(negedge clk);
        r0_rready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
